// File: rtl/alu_serie_param.sv
// rtl/alu_serie_param.sv - bit-serial WIDTH-bit ALU built around a 1-bit add/logic slice
// One operand bit per clock, LSB first; start/busy/done handshake with registered flags.

module alu_serie_slice (
  input  logic       x,
  input  logic       y,
  input  logic       cin,
  input  logic [1:0] op,
  output logic       s,
  output logic       cout
);

  always_comb begin
    s    = x ^ y ^ cin;
    cout = (x & y) | (x & cin) | (y & cin);
    case (op)
      2'b10: begin
        s    = x & y;
        cout = cin;
      end
      2'b11: begin
        s    = x | y;
        cout = cin;
      end
      default: ;
    endcase
  end

endmodule

module alu_serie_param #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic             carry,
  output logic             zero,
  output logic             overflow
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  localparam logic [1:0] OP_SUB = 2'b01;

  localparam int            CW   = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  logic [1:0]       state;
  logic [1:0]       op_q;
  logic [WIDTH-1:0] sa;
  logic [WIDTH-1:0] sb;
  logic [WIDTH-1:0] p;
  logic [CW-1:0]    cnt;
  logic             c;
  logic             cin_msb;
  logic             s_bit;
  logic             c_next;
  logic             arith;

  // ADD and SUB share the adder path; op_q[1] selects the bitwise ops.
  assign arith = ~op_q[1];

  alu_serie_slice u_slice (
    .x    (sa[0]),
    .y    (sb[0]),
    .cin  (c),
    .op   (op_q),
    .s    (s_bit),
    .cout (c_next)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= S_IDLE;
      op_q     <= '0;
      sa       <= '0;
      sb       <= '0;
      p        <= '0;
      cnt      <= '0;
      c        <= 1'b0;
      cin_msb  <= 1'b0;
      busy     <= 1'b0;
      done     <= 1'b0;
      result   <= '0;
      carry    <= 1'b0;
      zero     <= 1'b1;
      overflow <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        S_IDLE: begin
          busy <= start;
          if (start) begin
            // SUB is a + ~b + 1: invert B here and preload the carry.
            sa    <= a;
            sb    <= (op == OP_SUB) ? ~b : b;
            op_q  <= op;
            cnt   <= '0;
            c     <= (op == OP_SUB);
            p     <= '0;
            state <= S_RUN;
          end
        end
        S_RUN: begin
          busy <= 1'b1;
          sa   <= sa >> 1;
          sb   <= sb >> 1;
          p    <= {s_bit, p[WIDTH-1:1]};
          c    <= c_next;
          cnt  <= cnt + 1'b1;
          if (cnt == LAST) begin
            cin_msb <= c;
            state   <= S_DONE;
          end
        end
        S_DONE: begin
          busy     <= 1'b1;
          result   <= p;
          carry    <= arith & c;
          overflow <= arith & (cin_msb ^ c);
          zero     <= (p == '0);
          done     <= 1'b1;
          state    <= S_IDLE;
        end
        default: begin
          busy  <= 1'b0;
          state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_alu_serie_param.sv
// tb/tb_alu_serie_param.sv - randomized/exhaustive bench for alu_serie_param at WIDTH 8, 2, 4, 16
// All four instances share stimulus; an arithmetic reference model checks every instance every cycle.

module tb_alu_serie_param;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic [1:0]  op;
  logic [31:0] a_bus;
  logic [31:0] b_bus;

  logic        busy_w  [4];
  logic        done_w  [4];
  logic        carry_w [4];
  logic        zero_w  [4];
  logic        ovf_w   [4];
  logic [31:0] res_w   [4];

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  function automatic int wid(input int g);
    case (g)
      0:       return 8;
      1:       return 2;
      2:       return 4;
      default: return 16;
    endcase
  endfunction

  for (genvar g = 0; g < 4; g++) begin : u
    localparam int W = (g == 0) ? 8 : (g == 1) ? 2 : (g == 2) ? 4 : 16;
    logic [W-1:0] r;
    alu_serie_param #(.WIDTH(W)) dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .start    (start),
      .op       (op),
      .a        (a_bus[W-1:0]),
      .b        (b_bus[W-1:0]),
      .busy     (busy_w[g]),
      .done     (done_w[g]),
      .result   (r),
      .carry    (carry_w[g]),
      .zero     (zero_w[g]),
      .overflow (ovf_w[g])
    );
    assign res_w[g] = 32'(r);
  end

  // Reference model state: one entry per instance.
  bit          act    [4];
  int          t      [4];
  logic [31:0] e_res  [4];
  logic [31:0] p_res  [4];
  bit          e_c    [4];
  bit          e_z    [4];
  bit          e_v    [4];
  bit          e_done [4];
  bit          p_c    [4];
  bit          p_z    [4];
  bit          p_v    [4];

  task automatic ref_calc(input int w, input logic [1:0] o, input logic [31:0] x, input logic [31:0] y,
                          output logic [31:0] r, output bit c, output bit z, output bit v);
    longint unsigned m;
    longint unsigned xa;
    longint unsigned yb;
    longint unsigned full;
    bit sx, sy, sr;
    m  = (64'd1 << w) - 64'd1;
    xa = {32'd0, x} & m;
    yb = {32'd0, y} & m;
    c  = 1'b0;
    case (o)
      2'd0: begin
        full = xa + yb;
        c    = ((full >> w) & 64'd1) != 0;
        full = full & m;
      end
      2'd1: begin
        full = (xa - yb) & m;
        c    = (xa >= yb);
      end
      2'd2:    full = xa & yb;
      default: full = xa | yb;
    endcase
    r  = full[31:0];
    sx = x[w-1];
    sy = y[w-1];
    sr = r[w-1];
    if (o == 2'd0)      v = (sx == sy) && (sr != sx);
    else if (o == 2'd1) v = (sx != sy) && (sr != sx);
    else                v = 1'b0;
    z = (r == 32'd0);
  endtask

  task automatic model_reset();
    for (int g = 0; g < 4; g++) begin
      act[g]    = 1'b0;
      t[g]      = 0;
      e_res[g]  = '0;
      e_c[g]    = 1'b0;
      e_z[g]    = 1'b1;
      e_v[g]    = 1'b0;
      e_done[g] = 1'b0;
    end
  endtask

  task automatic model_step();
    for (int g = 0; g < 4; g++) begin
      e_done[g] = 1'b0;
      if (act[g]) begin
        t[g]++;
        if (t[g] == wid(g) + 1) begin
          e_res[g]  = p_res[g];
          e_c[g]    = p_c[g];
          e_z[g]    = p_z[g];
          e_v[g]    = p_v[g];
          e_done[g] = 1'b1;
        end
        if (t[g] == wid(g) + 2) act[g] = 1'b0;
      end
      if (!act[g] && start) begin
        act[g] = 1'b1;
        t[g]   = 0;
        ref_calc(wid(g), op, a_bus, b_bus, p_res[g], p_c[g], p_z[g], p_v[g]);
      end
    end
  endtask

  task automatic compare_all();
    for (int g = 0; g < 4; g++) begin
      checks++;
      if (busy_w[g] !== act[g] || done_w[g] !== e_done[g] || res_w[g] !== e_res[g] ||
          carry_w[g] !== e_c[g] || zero_w[g] !== e_z[g] || ovf_w[g] !== e_v[g]) begin
        errors++;
        $display("FAIL cycle W=%0d t=%0t: got busy=%b done=%b result=%h carry=%b zero=%b ovf=%b, want busy=%b done=%b result=%h carry=%b zero=%b ovf=%b",
                 wid(g), $time, busy_w[g], done_w[g], res_w[g], carry_w[g], zero_w[g], ovf_w[g],
                 act[g], e_done[g], e_res[g], e_c[g], e_z[g], e_v[g]);
      end
    end
  endtask

  task automatic tick();
    @(posedge clk);
    if (rst_n) model_step();
    else       model_reset();
    @(negedge clk);
    compare_all();
  endtask

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h want %h", nm, got, exp);
    end
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    start = 1'b0;
    do begin
      a_bus = $urandom();
      b_bus = $urandom();
      op    = 2'($urandom());
      tick();
      n++;
    end while ((busy_w[0] | busy_w[1] | busy_w[2] | busy_w[3]) && n < 40);
    checks++;
    if (n >= 40) begin
      errors++;
      $display("FAIL idle-timeout: still busy after %0d cycles, want idle within 40", n);
    end
  endtask

  task automatic run_op(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y,
                        input logic [31:0] er, input bit ec, input bit ez, input bit ev,
                        input string nm, input bit disturb);
    int n;
    op    = o;
    a_bus = ($urandom() & 32'hFFFF_FF00) | x;
    b_bus = ($urandom() & 32'hFFFF_FF00) | y;
    start = 1'b1;
    tick();
    start = 1'b0;
    n = 0;
    while (n < 20) begin
      if (disturb) begin
        op    = 2'($urandom());
        a_bus = $urandom();
        b_bus = $urandom();
        start = 1'($urandom_range(0, 1));
      end
      tick();
      n++;
      if (done_w[0]) break;
    end
    start = 1'b0;
    chk({nm, " latency"}, n, 9);
    chk({nm, " result"}, res_w[0], er);
    chk({nm, " carry"}, 32'(carry_w[0]), 32'(ec));
    chk({nm, " zero"}, 32'(zero_w[0]), 32'(ez));
    chk({nm, " overflow"}, 32'(ovf_w[0]), 32'(ev));
    wait_idle();
  endtask

  initial begin
    logic [31:0] r;
    bit c, z, v;
    int last, pulses;

    rst_n = 1'b0;
    start = 1'b0;
    op    = 2'd0;
    a_bus = '0;
    b_bus = '0;
    model_reset();

    // Pin the reference model to hand-computed vectors.
    ref_calc(8, 2'd0, 32'h7F, 32'h01, r, c, z, v);
    chk("model add 7f+01", {r[7:0], 5'd0, c, z, v}, {8'h80, 5'd0, 3'b001});
    ref_calc(8, 2'd1, 32'h03, 32'h05, r, c, z, v);
    chk("model sub 03-05", {r[7:0], 5'd0, c, z, v}, {8'hFE, 5'd0, 3'b000});
    ref_calc(8, 2'd1, 32'h80, 32'h01, r, c, z, v);
    chk("model sub 80-01", {r[7:0], 5'd0, c, z, v}, {8'h7F, 5'd0, 3'b101});
    ref_calc(4, 2'd0, 32'h9, 32'h9, r, c, z, v);
    chk("model add4 9+9", {r[7:0], 5'd0, c, z, v}, {8'h02, 5'd0, 3'b101});

    repeat (3) tick();
    chk("reset busy", 32'(busy_w[0]), 32'd0);
    chk("reset done", 32'(done_w[0]), 32'd0);
    chk("reset result", res_w[0], 32'd0);
    chk("reset zero", 32'(zero_w[0]), 32'd1);
    chk("reset carry", 32'(carry_w[0]), 32'd0);
    chk("reset overflow", 32'(ovf_w[0]), 32'd0);
    rst_n = 1'b1;
    tick();

    run_op(2'd0, 32'h7F, 32'h01, 32'h80, 1'b0, 1'b0, 1'b1, "add 7f+01", 1'b0);
    run_op(2'd0, 32'hFF, 32'h01, 32'h00, 1'b1, 1'b1, 1'b0, "add ff+01", 1'b0);
    run_op(2'd1, 32'h05, 32'h05, 32'h00, 1'b1, 1'b1, 1'b0, "sub 05-05", 1'b0);
    run_op(2'd1, 32'h03, 32'h05, 32'hFE, 1'b0, 1'b0, 1'b0, "sub 03-05", 1'b0);
    run_op(2'd1, 32'h80, 32'h01, 32'h7F, 1'b1, 1'b0, 1'b1, "sub 80-01", 1'b0);
    run_op(2'd2, 32'hF0, 32'h3C, 32'h30, 1'b0, 1'b0, 1'b0, "and f0&3c", 1'b0);
    run_op(2'd3, 32'hF0, 32'h0C, 32'hFC, 1'b0, 1'b0, 1'b0, "or f0|0c", 1'b0);
    run_op(2'd0, 32'h7F, 32'h01, 32'h80, 1'b0, 1'b0, 1'b1, "add disturbed", 1'b1);

    // start held high: WIDTH=8 instance must repeat every WIDTH+2 cycles.
    last   = -1;
    pulses = 0;
    op     = 2'd0;
    a_bus  = 32'h12;
    b_bus  = 32'h34;
    start  = 1'b1;
    for (int i = 0; i < 45; i++) begin
      tick();
      if (done_w[0]) begin
        if (last >= 0) chk("held interval", i - last, 10);
        last = i;
        pulses++;
      end
    end
    start = 1'b0;
    chk("held pulse count", pulses, 4);
    wait_idle();

    // Exhaustive 4-bit operand space (covers WIDTH=2 and 4 fully), random upper bits.
    for (int o = 0; o < 4; o++)
      for (int x = 0; x < 16; x++)
        for (int y = 0; y < 16; y++) begin
          op    = 2'(o);
          a_bus = ($urandom() & 32'hFFFF_FFF0) | 32'(x);
          b_bus = ($urandom() & 32'hFFFF_FFF0) | 32'(y);
          start = 1'b1;
          tick();
          wait_idle();
        end

    for (int i = 0; i < 300; i++) begin
      op    = 2'($urandom());
      a_bus = $urandom();
      b_bus = $urandom();
      start = 1'b1;
      tick();
      wait_idle();
    end

    // Asynchronous reset in the middle of RUN: no done, immediate reset values.
    op    = 2'd0;
    a_bus = $urandom();
    b_bus = $urandom();
    start = 1'b1;
    tick();
    start = 1'b0;
    repeat (4) tick();
    #2 rst_n = 1'b0;
    #1;
    model_reset();
    compare_all();
    chk("midrun reset busy", 32'(busy_w[0]), 32'd0);
    chk("midrun reset result", res_w[3], 32'd0);
    chk("midrun reset zero", 32'(zero_w[0]), 32'd1);
    repeat (2) tick();
    rst_n = 1'b1;
    tick();
    run_op(2'd0, 32'h21, 32'h10, 32'h31, 1'b0, 1'b0, 1'b0, "post-reset add", 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
